// File: rtl/shift_feeder_pkg.sv
// Shared types and constants for the shift feeder.
// States, word geometry and FIFO depth.
package shift_feeder_pkg;

  localparam int WORD_W        = 8;
  localparam int BITS_PER_WORD = 8;
  localparam int FIFO_DEPTH    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/shift_feeder_fifo.sv
// Byte buffer for the shift feeder.
// Registered full/empty flags; no pass-through when full.
module shift_feeder_fifo
  import shift_feeder_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int W     = WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_nxt = cnt;
    unique case ({do_push, do_pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  // Pointers, count and the flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == CW'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

  // Storage write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/shift_feeder.sv
// Load/shift control sequencer for an 8-bit serial shift stage.
// SHIFT_FEEDER_FIFO_EN selects a 4-deep FIFO over a 1-byte holding register.
module shift_feeder
  import shift_feeder_pkg::*;
#(
  parameter int   DIV      = 4,
  parameter logic FILL_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              load,
  output logic [WORD_W-1:0] parallel_data_out,
  output logic              enable,
  output logic              serial_fill,
  output logic              busy,
  output logic              frame_done
);

`ifdef SHIFT_FEEDER_FIFO_EN
  localparam int BUF_DEPTH = FIFO_DEPTH;
`else
  localparam int BUF_DEPTH = 1;
`endif

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX  = DW'(DIV - 1);
  localparam logic [2:0]    LAST_BIT = 3'(BITS_PER_WORD - 1);

  state_t            state;
  state_t            nxt;
  logic [DW-1:0]     div_cnt;
  logic [DW-1:0]     div_d;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_d;
  logic              load_d;
  logic              en_d;
  logic              fd_d;
  logic              busy_d;
  logic [WORD_W-1:0] pdo_d;
  logic [WORD_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push;

  assign serial_fill = FILL_BIT;
  assign in_ready    = !full;
  assign push        = in_valid && in_ready;

  shift_feeder_fifo #(
    .DEPTH (BUF_DEPTH),
    .W     (WORD_W)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (load_d),
    .din   (in_data),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      div_cnt           <= '0;
      bit_cnt           <= '0;
      load              <= 1'b0;
      enable            <= 1'b0;
      frame_done        <= 1'b0;
      busy              <= 1'b0;
      parallel_data_out <= '0;
    end else begin
      state             <= nxt;
      div_cnt           <= div_d;
      bit_cnt           <= bit_d;
      load              <= load_d;
      enable            <= en_d;
      frame_done        <= fd_d;
      busy              <= busy_d;
      parallel_data_out <= pdo_d;
    end
  end

  // Next state; frame_done marks the last strobe cycle.
  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (!empty) nxt = ST_LOAD;
      end
      ST_LOAD: begin
        nxt = abort ? ST_IDLE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort)
          nxt = ST_IDLE;
        else if (frame_done)
          nxt = empty ? ST_IDLE : ST_LOAD;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Next values of counters and strobes.
  always_comb begin
    div_d = '0;
    bit_d = '0;
    unique case (state)
      ST_SHIFT: begin
        div_d = (div_cnt == DIV_MAX) ? '0
                                     : div_cnt + 1'b1;
        bit_d = enable ? bit_cnt + 1'b1 : bit_cnt;
      end
      default: begin
        div_d = '0;
        bit_d = '0;
      end
    endcase
    en_d   = (nxt == ST_SHIFT) && (div_d == DIV_MAX);
    fd_d   = en_d && (bit_d == LAST_BIT);
    load_d = (nxt == ST_LOAD);
    busy_d = (nxt != ST_IDLE);
    pdo_d  = load_d ? head : parallel_data_out;
  end

endmodule

// File: tb/tb_shift_feeder.sv
// Directed bench for shift_feeder.
// Two instances: DIV=4 and DIV=1 sharing one input stream.
module tb_shift_feeder;

  typedef struct {
    int         cyc;
    logic       ld;
    logic       en;
    logic       fd;
    logic       bz;
    logic [7:0] pd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       abort = 1'b0;

  logic       rdy_a, ld_a, en_a, sf_a, bz_a, fd_a;
  logic [7:0] pd_a;
  logic       rdy_b, ld_b, en_b, sf_b, bz_b, fd_b;
  logic [7:0] pd_b;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = -1;
  int abort_cyc = -100;
  int nacc = 0;
  bit sel = 1'b0;
  logic [7:0] q[$];

  logic       lg_ld [256];
  logic       lg_en [256];
  logic       lg_fd [256];
  logic       lg_bz [256];
  logic [7:0] lg_pd [256];

  vec_t va[9];
  vec_t vb[5];
  vec_t vc[4];
  vec_t vd[5];

  always #5 clk = ~clk;

  shift_feeder #(.DIV(4), .FILL_BIT(1'b0)) dut_a (
    .clk (clk), .rst_n (rst_n),
    .in_data (in_data), .in_valid (in_valid),
    .in_ready (rdy_a), .abort (abort),
    .load (ld_a), .parallel_data_out (pd_a),
    .enable (en_a), .serial_fill (sf_a),
    .busy (bz_a), .frame_done (fd_a)
  );

  shift_feeder #(.DIV(1), .FILL_BIT(1'b1)) dut_b (
    .clk (clk), .rst_n (rst_n),
    .in_data (in_data), .in_valid (in_valid),
    .in_ready (rdy_b), .abort (abort),
    .load (ld_b), .parallel_data_out (pd_b),
    .enable (en_b), .serial_fill (sf_b),
    .busy (bz_b), .frame_done (fd_b)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    string s;
    s = $sformatf("%s@%0d", tag, v.cyc);
    chk({s, " load"}, 32'(lg_ld[v.cyc]), 32'(v.ld));
    chk({s, " enable"}, 32'(lg_en[v.cyc]), 32'(v.en));
    chk({s, " frame_done"}, 32'(lg_fd[v.cyc]), 32'(v.fd));
    chk({s, " busy"}, 32'(lg_bz[v.cyc]), 32'(v.bz));
    chk({s, " pdo"}, 32'(lg_pd[v.cyc]), 32'(v.pd));
  endtask

  task automatic step();
    logic acc;
    logic rdy;
    abort = (cyc == abort_cyc);
    if (q.size() > 0) begin
      in_valid = 1'b1;
      in_data  = q[0];
    end else begin
      in_valid = 1'b0;
      in_data  = '0;
    end
    rdy = sel ? rdy_b : rdy_a;
    acc = in_valid && rdy;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      void'(q.pop_front());
      nacc++;
    end
    if (cyc >= 0 && cyc < 256) begin
      lg_ld[cyc] = sel ? ld_b : ld_a;
      lg_en[cyc] = sel ? en_b : en_a;
      lg_fd[cyc] = sel ? fd_b : fd_a;
      lg_bz[cyc] = sel ? bz_b : bz_a;
      lg_pd[cyc] = sel ? pd_b : pd_a;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " load"}, 32'(ld_a | ld_b), 0);
    chk({tag, " enable"}, 32'(en_a | en_b), 0);
    chk({tag, " busy"}, 32'(bz_a | bz_b), 0);
    chk({tag, " frame_done"}, 32'(fd_a | fd_b), 0);
    chk({tag, " pdo"}, 32'(pd_a | pd_b), 0);
    chk({tag, " in_ready"}, 32'(rdy_a & rdy_b), 1);
  endtask

  task automatic do_reset(input string tag);
    q.delete();
    in_valid = 1'b0;
    abort = 1'b0;
    abort_cyc = -100;
    nacc = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = -1;
    for (int i = 0; i < 256; i++) begin
      lg_ld[i] = 1'bx;
      lg_en[i] = 1'bx;
      lg_fd[i] = 1'bx;
      lg_bz[i] = 1'bx;
      lg_pd[i] = 'x;
    end
  endtask

  initial begin
    int n;
    bit ok;
    logic exp_en;

    va = '{
      '{0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
      '{1,  1'b1, 1'b0, 1'b0, 1'b1, 8'hA5},
      '{2,  1'b0, 1'b0, 1'b0, 1'b1, 8'hA5},
      '{4,  1'b0, 1'b0, 1'b0, 1'b1, 8'hA5},
      '{5,  1'b0, 1'b1, 1'b0, 1'b1, 8'hA5},
      '{9,  1'b0, 1'b1, 1'b0, 1'b1, 8'hA5},
      '{32, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5},
      '{33, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5},
      '{34, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5}
    };
    vb = '{
      '{1,  1'b1, 1'b0, 1'b0, 1'b1, 8'h3C},
      '{33, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C},
      '{34, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3},
      '{66, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC3},
      '{67, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3}
    };
    vc = '{
      '{1,  1'b1, 1'b0, 1'b0, 1'b1, 8'hFF},
      '{2,  1'b0, 1'b1, 1'b0, 1'b1, 8'hFF},
      '{9,  1'b0, 1'b1, 1'b1, 1'b1, 8'hFF},
      '{10, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF}
    };
    vd = '{
      '{9,  1'b0, 1'b1, 1'b0, 1'b1, 8'hA5},
      '{10, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5},
      '{11, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5},
      '{12, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A},
      '{13, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A}
    };

    chk("serial_fill a", 32'(sf_a), 0);
    chk("serial_fill b", 32'(sf_b), 1);

    // Single byte, DIV=4.
    do_reset("rst0");
    sel = 1'b0;
    q.push_back(8'hA5);
    repeat (40) step();
    foreach (va[i]) chk_vec("single", va[i]);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      exp_en = (i >= 5 && i <= 33 && (i - 5) % 4 == 0);
      if (lg_en[i] !== exp_en) ok = 1'b0;
      if (lg_fd[i] !== (i == 33)) ok = 1'b0;
    end
    chk("single strobe pattern", 32'(ok), 1);

    // Two bytes back to back, DIV=4.
    do_reset("rst1");
    q.push_back(8'h3C);
    q.push_back(8'hC3);
    repeat (70) step();
    foreach (vb[i]) chk_vec("b2b", vb[i]);
    n = 0;
    for (int i = 0; i < 70; i++) n += int'(lg_en[i] === 1'b1);
    chk("b2b strobe count", 32'(n), 16);
    n = 0;
    for (int i = 1; i <= 66; i++) n += int'(lg_bz[i] === 1'b1);
    chk("b2b busy run", 32'(n), 66);
    chk("b2b busy c0", 32'(lg_bz[0]), 0);

    // Hold in_valid with a stream to find buffer depth.
    do_reset("rst2");
    for (int i = 0; i < 8; i++) q.push_back(8'(i + 1));
    repeat (8) step();
`ifdef SHIFT_FEEDER_FIFO_EN
    chk("fill accepts", 32'(nacc), 5);
`else
    chk("fill accepts", 32'(nacc), 2);
`endif
    chk("fill in_ready", 32'(rdy_a), 0);

    // Abort mid-frame with a byte buffered.
    do_reset("rst3");
    q.push_back(8'hA5);
    q.push_back(8'h5A);
    abort_cyc = 10;
    repeat (16) step();
    foreach (vd[i]) chk_vec("abort", vd[i]);
    n = 0;
    for (int i = 0; i <= 13; i++) n += int'(lg_fd[i] === 1'b1);
    chk("abort no frame_done", 32'(n), 0);

    // DIV=1 single byte.
    do_reset("rst4");
    sel = 1'b1;
    q.push_back(8'hFF);
    repeat (14) step();
    foreach (vc[i]) chk_vec("div1", vc[i]);
    n = 0;
    for (int i = 2; i <= 9; i++) n += int'(lg_en[i] === 1'b1);
    chk("div1 strobe run", 32'(n), 8);

    // Reset mid-SHIFT with bytes buffered.
    do_reset("rst5");
    sel = 1'b0;
    q.push_back(8'h11);
    q.push_back(8'h22);
    q.push_back(8'h33);
    repeat (12) step();
    chk("pre-reset busy", 32'(bz_a), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async rst");
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = -1;
    repeat (20) step();
    n = 0;
    for (int i = 0; i < 20; i++)
      n += int'(lg_ld[i] !== 1'b0) + int'(lg_bz[i] !== 1'b0);
    chk("post-reset idle", 32'(n), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_feeder.md
# shift_feeder

Upstream driver for the 8-bit serial shift stage. Accepts bytes over a valid/ready handshake, buffers them, and produces the `load` / `parallel_data_out` / `enable` control sequence that loads one byte and then clocks it out with eight evenly spaced shift strobes. Back-to-back bytes stream out without idle gaps beyond a single load cycle.

## Interface

Parameters:
- `DIV`, 4: clock cycles per shift strobe, ≥1.
- `FILL_BIT`, 1'b0: constant value driven on `serial_fill`, the downstream serial input.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  byte to transmit.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  buffer can accept; transfer when `in_valid && in_ready` at a rising edge.
- `abort`  in  1  synchronous; drop the byte in flight.
- `load`  out  1  one-cycle parallel-load strobe to the shift stage.
- `parallel_data_out`  out  8  byte presented with `load`; holds until next load.
- `enable`  out  1  one-cycle shift strobe.
- `serial_fill`  out  1  equals `FILL_BIT`.
- `busy`  out  1  high in LOAD or SHIFT.
- `frame_done`  out  1  one-cycle pulse on the 8th shift strobe.

## Operation

- States: IDLE, LOAD, SHIFT.
- IDLE: `load`=0, `enable`=0. If buffer non-empty → LOAD.
- LOAD (1 cycle): `load`=1, `parallel_data_out` = buffer head, pop head. Clear `div_cnt` and `bit_cnt`. → SHIFT.
- SHIFT:
  - `div_cnt` counts 0..DIV-1 and wraps.
  - `enable`=1 in the cycle `div_cnt`==DIV-1, then `bit_cnt`++.
  - On the 8th strobe (`bit_cnt`==7), assert `frame_done` with `enable`.
  - Then go to LOAD if the buffer is non-empty, otherwise IDLE.
- Abort: `abort`=1 in LOAD or SHIFT → IDLE next cycle.
  - No `enable`/`frame_done` that cycle.
  - Buffered bytes are kept.
  - `abort` in IDLE has no effect.
- Buffer: `in_ready` = !full.
  - Push and pop may occur in the same cycle when not full.
  - When full, `in_ready`=0 regardless of a same-cycle pop (no pass-through).
- Counters: `div_cnt` width = max(1, $clog2(DIV)). `bit_cnt` is 3 bits.
- DIV=1: `enable` high every SHIFT cycle.
- Reset values: `load`, `enable`, `busy`, `frame_done` = 0; `parallel_data_out` = 8'h00; `in_ready` = 1; buffer empty; state IDLE.
- Reset mid-frame takes effect asynchronously. All outputs return to their reset values.

## Timing

- All outputs registered except `serial_fill` (constant) and `in_ready` (from the buffer-full flag register).
- Accept at edge N into an empty buffer while IDLE → `load` high in cycle N+1.
- First `enable` at cycle N+1+DIV. 8th `enable` and `frame_done` at N+1+8·DIV.
- Back-to-back: next `load` in the cycle after the 8th strobe. Frame period = 8·DIV+1 cycles.
- `parallel_data_out` changes only in cycles where `load`=1.

## Configuration

- `SHIFT_FEEDER_FIFO_EN` defined: buffer is a 4-entry FIFO. `in_ready` falls after the 4th unpopped byte.
- Undefined: buffer is a single holding register. `in_ready`=0 while it is occupied.
- The frame sequence is identical in both builds; only buffer depth differs.

## Structure

- Package `shift_feeder_pkg` holds:
  - state enum (IDLE/LOAD/SHIFT);
  - `WORD_W`=8, `BITS_PER_WORD`=8;
  - `FIFO_DEPTH`=4.
- One sub-module `shift_feeder_fifo`, parameterized depth.
  - Provides push/pop/head/full/empty.
  - Depth 1 when the macro is undefined.
- The FSM and counters stay in the top module.

## Test plan

- Reset, then push 8'hA5 at edge 0, DIV=4 → `load`=1 with `parallel_data_out`=8'hA5 at cycle 1; `enable` at cycles 5, 9, …, 33; `frame_done` at 33; IDLE at 34.
- Push 8'h3C and 8'hC3 consecutively, DIV=4 → second `load` at cycle 34 with 8'hC3; 16 strobes total; `busy` continuous cycles 1–66.
- Macro defined, hold `in_valid` with a stream of bytes → `in_ready` drops after 5 accepts (1 loaded + 4 buffered). Macro undefined → drops after 2 accepts.
- `abort` at cycle 10 during 8'hA5, 8'h5A buffered → no `enable` after cycle 9; `load` with 8'h5A at cycle 12.
- DIV=1, push 8'hFF → `enable` high for 8 consecutive cycles 2–9; `frame_done` at 9.
- Assert `rst_n`=0 mid-SHIFT with 2 bytes buffered → outputs at reset values immediately; no `load` after release until a new push.
